imem_sram_responder: RTL and testbench

- Memory-side responder for the fetch stage. The fetch stage issues a word-address request; this block answers it from a 16-bit-wide external SRAM.
- Each request becomes two sequential half-word reads with a programmable wait count. The two halves are assembled into a 32-bit instruction and returned with a one-cycle ready pulse.
- Drives a freeze signal back to the fetch stage while a fetch is outstanding. Honours branch flush by aborting the in-flight fetch.

---
 rtl/imem_sram_responder_if.sv | 26 ++
 rtl/imem_sram_responder.sv | 110 +++++++++++
 tb/tb_imem_sram_responder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_sram_responder_if.sv
// Fetch-stage request/response and 16-bit SRAM read bus for imem_sram_responder.
// The responder takes the slave view; the fetch stage and the SRAM take the master view.
interface imem_sram_responder_if #(
  parameter int unsigned ADDR_W = 18
);
  logic              req;
  logic [31:0]       addr;
  logic              flush;
  logic              ready;
  logic [31:0]       instruction;
  logic              busy;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq;
  logic              sram_oe_n;
  logic              sram_we_n;

  modport master (
    output req, addr, flush, sram_dq,
    input  ready, instruction, busy, sram_addr, sram_oe_n, sram_we_n
  );

  modport slave (
    input  req, addr, flush, sram_dq,
    output ready, instruction, busy, sram_addr, sram_oe_n, sram_we_n
  );
endinterface

// File: rtl/imem_sram_responder.sv
// Answers fetch-stage word requests with two sequential half-word reads from a
// 16-bit SRAM, assembling a 32-bit instruction and pulsing ready once.
module imem_sram_responder #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = 18
) (
  input logic                  clk,
  input logic                  rst,
  imem_sram_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t            state_r;
  logic [3:0]        wait_cnt_r;
  logic [ADDR_W-2:0] word_addr_r;
  logic [31:0]       instr_r;
  logic [ADDR_W-1:0] sram_addr_r;
  logic              oe_n_r;
  logic              last_s;
  logic              ready_s;
  logic              unused_addr_s;

  assign last_s = (wait_cnt_r == WAIT_LAST);

  // Fetch sequencer: request latch, half-word access timing and data capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      wait_cnt_r  <= 4'd0;
      word_addr_r <= '0;
      instr_r     <= 32'd0;
      sram_addr_r <= '0;
      oe_n_r      <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          wait_cnt_r <= 4'd0;
          if (bus.req && !bus.flush) begin
            word_addr_r <= bus.addr[ADDR_W:2];
            sram_addr_r <= {bus.addr[ADDR_W:2], 1'b0};
            oe_n_r      <= 1'b0;
            state_r     <= LOW;
          end else begin
            oe_n_r  <= 1'b1;
            state_r <= IDLE;
          end
        end
        LOW: begin
          if (bus.flush) begin
            wait_cnt_r <= 4'd0;
            oe_n_r     <= 1'b1;
            state_r    <= IDLE;
          end else if (last_s) begin
            instr_r[15:0] <= bus.sram_dq;
            sram_addr_r   <= {word_addr_r, 1'b1};
            wait_cnt_r    <= 4'd0;
            state_r       <= HIGH;
          end else begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
          end
        end
        HIGH: begin
          if (bus.flush) begin
            wait_cnt_r <= 4'd0;
            oe_n_r     <= 1'b1;
            state_r    <= IDLE;
          end else if (last_s) begin
            instr_r[31:16] <= bus.sram_dq;
            wait_cnt_r     <= 4'd0;
            oe_n_r         <= 1'b1;
            state_r        <= DONE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
          end
        end
        DONE: begin
          // A new request is only taken from IDLE, giving one gap cycle.
          wait_cnt_r <= 4'd0;
          oe_n_r     <= 1'b1;
          state_r    <= IDLE;
        end
        default: begin
          wait_cnt_r <= 4'd0;
          oe_n_r     <= 1'b1;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  // Flush in the DONE cycle must suppress the pulse, so ready gates on flush.
  assign ready_s         = (state_r == DONE) && !bus.flush;
  assign bus.ready       = ready_s;
  assign bus.busy        = (bus.req || (state_r != IDLE)) && !ready_s;
  assign bus.instruction = instr_r;
  assign bus.sram_addr   = sram_addr_r;
  assign bus.sram_oe_n   = oe_n_r;
  assign bus.sram_we_n   = 1'b1;

  assign unused_addr_s = ^{bus.addr[31:ADDR_W+1], bus.addr[1:0]};

endmodule

// File: tb/tb_imem_sram_responder.sv
// Directed bench for imem_sram_responder: three instances at WAIT_CYCLES 0, 2 and 1
// sharing one SRAM image, checked with immediate assertions.
module tb_imem_sram_responder;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [15:0] mem [256];

  imem_sram_responder_if #(.ADDR_W(18)) ia ();
  imem_sram_responder_if #(.ADDR_W(18)) ib ();
  imem_sram_responder_if #(.ADDR_W(18)) ic ();

  imem_sram_responder #(.WAIT_CYCLES(0), .ADDR_W(18)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  imem_sram_responder #(.WAIT_CYCLES(2), .ADDR_W(18)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  imem_sram_responder #(.WAIT_CYCLES(1), .ADDR_W(18)) dut_c (.clk(clk), .rst(rst), .bus(ic));

  assign ia.sram_dq = mem[ia.sram_addr[7:0]];
  assign ib.sram_dq = mem[ib.sram_addr[7:0]];
  assign ic.sram_dq = mem[ic.sram_addr[7:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'h1111; mem[8'h01] = 16'h2222;
    mem[8'h02] = 16'h3333; mem[8'h03] = 16'h4444;
    mem[8'h04] = 16'h060A; mem[8'h05] = 16'h8001;
    mem[8'h06] = 16'h5566; mem[8'h07] = 16'h7788;
    mem[8'h10] = 16'hDEAD; mem[8'h11] = 16'hBEEF;
    mem[8'h80] = 16'h1234; mem[8'h81] = 16'hABCD;

    ia.req = 1'b0; ia.flush = 1'b0; ia.addr = 32'h0;
    ib.req = 1'b0; ib.flush = 1'b0; ib.addr = 32'h0;
    ic.req = 1'b0; ic.flush = 1'b0; ic.addr = 32'h0;

    // Power-up reset
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",     32'(ia.ready),       32'h0);
    chk("rst_instr",     ia.instruction,      32'h0);
    chk("rst_busy",      32'(ia.busy),        32'h0);
    chk("rst_sram_addr", 32'(ia.sram_addr),   32'h0);
    chk("rst_oe_n",      32'(ia.sram_oe_n),   32'h1);
    chk("rst_we_n",      32'(ia.sram_we_n),   32'h1);
    chk("rst_oe_n_b",    32'(ib.sram_oe_n),   32'h1);
    chk("rst_oe_n_c",    32'(ic.sram_oe_n),   32'h1);
    tick(); rst = 1'b1;
    tick(); @(negedge clk);
    chk("post_rst_busy", 32'(ia.busy),      32'h0);
    chk("post_rst_oe_n", 32'(ia.sram_oe_n), 32'h1);

    // Single fetch, WAIT_CYCLES=0, addr 0x8
    tick(); ia.req = 1'b1; ia.addr = 32'h0000_0008;
    @(negedge clk);
    chk("a1_n_busy",  32'(ia.busy),  32'h1);
    chk("a1_n_ready", 32'(ia.ready), 32'h0);
    tick(); @(negedge clk);
    chk("a1_low_addr", 32'(ia.sram_addr), 32'h4);
    chk("a1_low_oe_n", 32'(ia.sram_oe_n), 32'h0);
    chk("a1_low_busy", 32'(ia.busy),      32'h1);
    tick(); @(negedge clk);
    chk("a1_high_addr", 32'(ia.sram_addr), 32'h5);
    chk("a1_high_busy", 32'(ia.busy),      32'h1);
    tick(); @(negedge clk);
    chk("a1_ready",      32'(ia.ready),     32'h1);
    chk("a1_instr",      ia.instruction,    32'h8001_060A);
    chk("a1_done_busy",  32'(ia.busy),      32'h0);
    chk("a1_done_oe_n",  32'(ia.sram_oe_n), 32'h1);
    tick(); ia.req = 1'b0; @(negedge clk);
    chk("a1_after_ready", 32'(ia.ready), 32'h0);
    chk("a1_after_busy",  32'(ia.busy),  32'h0);

    // WAIT_CYCLES=2, addr 0x100
    tick(); ib.req = 1'b1; ib.addr = 32'h0000_0100;
    @(negedge clk);
    chk("b1_n_busy", 32'(ib.busy), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge clk);
      chk("b1_low_addr", 32'(ib.sram_addr), 32'h80);
      chk("b1_low_ready", 32'(ib.ready), 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge clk);
      chk("b1_high_addr", 32'(ib.sram_addr), 32'h81);
      chk("b1_high_busy", 32'(ib.busy), 32'h1);
    end
    tick(); @(negedge clk);
    chk("b1_ready", 32'(ib.ready), 32'h1);
    chk("b1_instr", ib.instruction, 32'hABCD_1234);
    chk("b1_busy",  32'(ib.busy),  32'h0);
    tick(); ib.req = 1'b0; @(negedge clk);
    chk("b1_after_ready", 32'(ib.ready), 32'h0);

    // Flush during HIGH, WAIT_CYCLES=1, addr 0x20
    tick(); ic.req = 1'b1; ic.addr = 32'h0000_0020;
    tick(); tick();
    tick(); ic.flush = 1'b1; ic.req = 1'b0; @(negedge clk);
    chk("c_flush_high_addr", 32'(ic.sram_addr), 32'h11);
    chk("c_flush_high_oe_n", 32'(ic.sram_oe_n), 32'h0);
    tick(); ic.flush = 1'b0; @(negedge clk);
    chk("c_flushed_ready", 32'(ic.ready),     32'h0);
    chk("c_flushed_oe_n",  32'(ic.sram_oe_n), 32'h1);
    chk("c_flushed_busy",  32'(ic.busy),      32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge clk);
      chk("c_no_ready", 32'(ic.ready), 32'h0);
    end
    tick(); ic.req = 1'b1; ic.addr = 32'h0000_000C;
    for (int i = 0; i < 2; i++) begin
      tick(); @(negedge clk);
      chk("c2_low_addr", 32'(ic.sram_addr), 32'h6);
    end
    for (int i = 0; i < 2; i++) begin
      tick(); @(negedge clk);
      chk("c2_high_addr", 32'(ic.sram_addr), 32'h7);
    end
    tick(); @(negedge clk);
    chk("c2_ready", 32'(ic.ready), 32'h1);
    chk("c2_instr", ic.instruction, 32'h7788_5566);
    tick(); ic.req = 1'b0;

    // Back-to-back fetches with req held, WAIT_CYCLES=0
    tick(); ia.req = 1'b1; ia.addr = 32'h0000_0000;
    tick(); tick(); tick(); @(negedge clk);
    chk("bb1_ready", 32'(ia.ready), 32'h1);
    chk("bb1_instr", ia.instruction, 32'h2222_1111);
    tick(); ia.addr = 32'h0000_0004; @(negedge clk);
    chk("bb_gap_ready", 32'(ia.ready), 32'h0);
    chk("bb_gap_busy",  32'(ia.busy),  32'h1);
    tick(); @(negedge clk);
    chk("bb2_low_addr", 32'(ia.sram_addr), 32'h2);
    tick(); @(negedge clk);
    chk("bb2_high_addr", 32'(ia.sram_addr), 32'h3);
    tick(); @(negedge clk);
    chk("bb2_ready", 32'(ia.ready), 32'h1);
    chk("bb2_instr", ia.instruction, 32'h4444_3333);
    tick(); ia.req = 1'b0; @(negedge clk);
    chk("bb2_after_ready", 32'(ia.ready), 32'h0);

    // req and flush together in IDLE
    tick(); ib.req = 1'b1; ib.flush = 1'b1; ib.addr = 32'h0000_0000;
    @(negedge clk);
    chk("rf_oe_n", 32'(ib.sram_oe_n), 32'h1);
    tick(); ib.req = 1'b0; ib.flush = 1'b0; @(negedge clk);
    chk("rf_next_oe_n", 32'(ib.sram_oe_n), 32'h1);
    chk("rf_next_busy", 32'(ib.busy),      32'h0);
    for (int i = 0; i < 2; i++) begin
      tick(); @(negedge clk);
      chk("rf_idle_oe_n",  32'(ib.sram_oe_n), 32'h1);
      chk("rf_idle_ready", 32'(ib.ready),     32'h0);
    end

    // Flush on the DONE cycle, WAIT_CYCLES=2
    tick(); ib.req = 1'b1; ib.addr = 32'h0000_0100;
    repeat (6) tick();
    tick(); ib.flush = 1'b1; ib.req = 1'b0; @(negedge clk);
    chk("fd_ready", 32'(ib.ready),     32'h0);
    chk("fd_oe_n",  32'(ib.sram_oe_n), 32'h1);
    tick(); ib.flush = 1'b0; @(negedge clk);
    chk("fd_next_ready", 32'(ib.ready), 32'h0);
    chk("fd_next_busy",  32'(ib.busy),  32'h0);

    // Asynchronous reset in the middle of a fetch
    tick(); ia.req = 1'b1; ia.addr = 32'h0000_0008;
    tick();
    #2; rst = 1'b0; ia.req = 1'b0;
    @(negedge clk);
    chk("mr_ready",     32'(ia.ready),     32'h0);
    chk("mr_instr",     ia.instruction,    32'h0);
    chk("mr_busy",      32'(ia.busy),      32'h0);
    chk("mr_sram_addr", 32'(ia.sram_addr), 32'h0);
    chk("mr_oe_n",      32'(ia.sram_oe_n), 32'h1);
    chk("mr_we_n",      32'(ia.sram_we_n), 32'h1);
    chk("mr_instr_c",   ic.instruction,    32'h0);
    tick(); @(negedge clk);
    chk("mr_hold_oe_n", 32'(ia.sram_oe_n), 32'h1);
    tick(); rst = 1'b1;
    tick(); @(negedge clk);
    chk("mr_rel_busy", 32'(ia.busy),      32'h0);
    chk("mr_rel_oe_n", 32'(ia.sram_oe_n), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
